// File: rtl/midi_pkg.sv
// Shared MIDI byte-class constants, parser state type and the note-to-playback-rate function.
package midi_pkg;

  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
  localparam logic [7:0] SYS_RT_MIN      = 8'hF8;
  localparam logic [7:0] SYS_COMMON_MIN  = 8'hF0;

  // 2^(1/12) in Q24 fixed point
  localparam longint SEMITONE_Q24 = 64'sd17774841;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_D1,
    WAIT_D2
  } parse_state_t;

  // round(clk_hz / (440 * 2^((n-69)/12) * wave)), done in integer fixed point
  function automatic longint note_rate(input int n, input longint clk_hz, input longint wave);
    longint semi, k, oct, ratio, num, den;
    semi  = longint'(n) - 64'sd69;
    k     = ((semi % 64'sd12) + 64'sd12) % 64'sd12;
    oct   = (semi - k) / 64'sd12;
    ratio = 64'sd1 <<< 24;
    for (int i = 0; i < 11; i++) begin
      if (longint'(i) < k) ratio = (ratio * SEMITONE_Q24 + (64'sd1 <<< 23)) >>> 24;
    end
    num = clk_hz <<< 24;
    den = 64'sd440 * wave * ratio;
    if (oct < 0) num = num <<< (-oct);
    else         den = den <<< oct;
    return (num + den / 64'sd2) / den;
  endfunction

endpackage

// File: rtl/midi_message_parser_if.sv
// Byte-stream input and note-event output bundle of the MIDI message parser.
interface midi_message_parser_if;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        valid_out;
  logic        is_note_on_out;
  logic [23:0] cycles_between_samples_out;
  logic [6:0]  note_out;
  logic [6:0]  velocity_out;
  logic [7:0]  error_count_out;

  modport master (
    output byte_in, byte_valid_in,
    input  valid_out, is_note_on_out, cycles_between_samples_out,
    input  note_out, velocity_out, error_count_out
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output valid_out, is_note_on_out, cycles_between_samples_out,
    output note_out, velocity_out, error_count_out
  );
endinterface

// File: rtl/midi_note_rate_lut.sv
// 128x24 ROM of wavetable playback rates per MIDI note, one-cycle registered read.
module midi_note_rate_lut
  import midi_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int WAVE_SAMPLES = 256
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rd_en,
  input  logic [6:0]  addr,
  output logic [23:0] rate
);

  logic [23:0] rom [128];

  for (genvar i = 0; i < 128; i++) begin : g_rom
    localparam longint RATE = note_rate(i, longint'(CLK_HZ), longint'(WAVE_SAMPLES));
    if (RATE <= 0 || RATE > 64'sh00FF_FFFF) begin : g_bad
      $error("note rate entry %0d does not fit in 24 bits or is zero", i);
    end
    assign rom[i] = RATE[23:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)  rate <= '0;
    else if (rd_en) rate <= rom[addr];
  end

endmodule

// File: rtl/midi_message_parser.sv
// MIDI byte stream to note on/off events, with running status, channel filter and real-time bypass.
module midi_message_parser
  import midi_pkg::*;
#(
  parameter int         CLK_HZ       = 100_000_000,
  parameter int         WAVE_SAMPLES = 256,
  parameter bit         OMNI         = 1'b1,
  parameter logic [3:0] CHANNEL      = 4'd0
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  midi_message_parser_if.slave bus
);

  parse_state_t state_q, state_d;
  logic [7:0] rs_q, rs_d;
  logic       rs_valid_q, rs_valid_d;
  logic       sys_ctx_q, sys_ctx_d;
  logic [6:0] d1_q, d1_d;
  logic [7:0] err_q, err_d;
  logic       done;
  logic [7:0] b;

  logic       ev_d, on_d;
  logic [6:0] vel_d;
  logic       ev_q, on_q;
  logic [6:0] note_q, vel_q;

  logic       valid_r, on_r;
  logic [6:0] note_r, vel_r;
  logic [23:0] rate;

  logic need_one, is_note, chan_ok;

  assign b        = bus.byte_in;
  assign need_one = (rs_q[7:5] == 3'b110);
  assign is_note  = (rs_q[7:4] == STATUS_NOTE_ON) || (rs_q[7:4] == STATUS_NOTE_OFF);
  assign chan_ok  = OMNI || (rs_q[3:0] == CHANNEL);

  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    rs_valid_d = rs_valid_q;
    sys_ctx_d  = sys_ctx_q;
    d1_d       = d1_q;
    err_d      = err_q;
    done       = 1'b0;
    if (bus.byte_valid_in) begin
      if (b >= SYS_RT_MIN) begin
        // real-time bytes pass through without touching parser state
      end else if (b >= SYS_COMMON_MIN) begin
        rs_valid_d = 1'b0;
        sys_ctx_d  = 1'b1;
        state_d    = WAIT_STATUS;
      end else if (b[7]) begin
        rs_d       = b;
        rs_valid_d = 1'b1;
        sys_ctx_d  = 1'b0;
        state_d    = WAIT_D1;
      end else begin
        case (state_q)
          WAIT_STATUS: if (!rs_valid_q && !sys_ctx_q && err_q != 8'hFF) err_d = err_q + 8'd1;
          WAIT_D1: begin
            d1_d = b[6:0];
            if (need_one) done = 1'b1;
            else          state_d = WAIT_D2;
          end
          WAIT_D2: begin
            done    = 1'b1;
            state_d = WAIT_D1;
          end
          default: state_d = WAIT_STATUS;
        endcase
      end
    end
  end

  // Single-data-byte messages never qualify as notes, so d1_q/b are always note/velocity here
  assign ev_d  = done && is_note && chan_ok;
  assign on_d  = (rs_q[7:4] == STATUS_NOTE_ON) && (b[6:0] != 7'd0);
  assign vel_d = on_d ? b[6:0] : 7'd0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= WAIT_STATUS;
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
      sys_ctx_q  <= 1'b0;
      d1_q       <= '0;
      err_q      <= '0;
      ev_q       <= 1'b0;
      on_q       <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      valid_r    <= 1'b0;
      on_r       <= 1'b0;
      note_r     <= '0;
      vel_r      <= '0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rs_valid_q <= rs_valid_d;
      sys_ctx_q  <= sys_ctx_d;
      d1_q       <= d1_d;
      err_q      <= err_d;
      ev_q       <= ev_d;
      if (ev_d) begin
        on_q   <= on_d;
        note_q <= d1_q;
        vel_q  <= vel_d;
      end
      valid_r <= ev_q;
      if (ev_q) begin
        on_r   <= on_q;
        note_r <= note_q;
        vel_r  <= vel_q;
      end
    end
  end

  midi_note_rate_lut #(
    .CLK_HZ      (CLK_HZ),
    .WAVE_SAMPLES(WAVE_SAMPLES)
  ) u_lut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .rd_en   (ev_q),
    .addr    (note_q),
    .rate    (rate)
  );

  assign bus.valid_out                  = valid_r;
  assign bus.is_note_on_out             = on_r;
  assign bus.note_out                   = note_r;
  assign bus.velocity_out               = vel_r;
  assign bus.cycles_between_samples_out = rate;
  assign bus.error_count_out            = err_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench: omni and channel-2 parsers fed the same byte stream, table vectors plus corner sequences.
module tb_midi_message_parser;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  midi_message_parser_if bus_a ();
  midi_message_parser_if bus_b ();

  midi_message_parser #(
    .CLK_HZ(100_000_000), .WAVE_SAMPLES(256), .OMNI(1'b1), .CHANNEL(4'd0)
  ) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n), .bus(bus_a)
  );

  midi_message_parser #(
    .CLK_HZ(100_000_000), .WAVE_SAMPLES(256), .OMNI(1'b0), .CHANNEL(4'd2)
  ) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n), .bus(bus_b)
  );

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        ev;
    logic        on;
    logic [6:0]  note;
    logic [6:0]  vel;
    logic [23:0] rate;
    logic        evb;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;
  int evcount  = 0;

  function automatic vec_t mk(input logic v, input logic [7:0] b, input logic ev, input logic on,
                              input logic [6:0] note, input logic [6:0] vel,
                              input logic [23:0] rate, input logic evb);
    vec_t r;
    r.v = v; r.b = b; r.ev = ev; r.on = on; r.note = note; r.vel = vel; r.rate = rate; r.evb = evb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Presents one byte (or an idle cycle) to both parsers, then samples just after the edge
  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clk_in);
    bus_a.byte_valid_in = v;
    bus_a.byte_in       = b;
    bus_b.byte_valid_in = v;
    bus_b.byte_in       = b;
    @(posedge clk_in);
    #1;
    if (bus_a.valid_out === 1'b1) evcount++;
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    bus_a.byte_valid_in = 1'b0;
    bus_b.byte_valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    evcount = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus_a.valid_out), 0);
    chk({tag, "_on"},    32'(bus_a.is_note_on_out), 0);
    chk({tag, "_note"},  32'(bus_a.note_out), 0);
    chk({tag, "_vel"},   32'(bus_a.velocity_out), 0);
    chk({tag, "_rate"},  32'(bus_a.cycles_between_samples_out), 0);
    chk({tag, "_err"},   32'(bus_a.error_count_out), 0);
  endtask

  initial begin
    bus_a.byte_valid_in = 1'b0; bus_a.byte_in = 8'h00;
    bus_b.byte_valid_in = 1'b0; bus_b.byte_in = 8'h00;

    //              v  byte   ev on note vel rate  evb
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0,    0, 0));
    vecs.push_back(mk(1, 8'h45, 0, 0,  0,   0,    0, 0));
    vecs.push_back(mk(1, 8'h64, 0, 0,  0,   0,    0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 69, 100,  888, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h90, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h45, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h64, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h51, 1, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 81,   0,  444, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 81,   0,  444, 0));
    vecs.push_back(mk(1, 8'h90, 0, 0, 81,   0,  444, 0));
    vecs.push_back(mk(1, 8'h45, 0, 0, 81,   0,  444, 0));
    vecs.push_back(mk(1, 8'hF8, 0, 0, 81,   0,  444, 0));
    vecs.push_back(mk(1, 8'h64, 0, 0, 81,   0,  444, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 69, 100,  888, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h91, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h45, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h64, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h82, 1, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h45, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(1, 8'h40, 0, 1, 69, 100,  888, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 69,   0,  888, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'hC0, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h06, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h90, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h80, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(1, 8'h10, 0, 0, 69,   0,  888, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 60,   0, 1493, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 60,   0, 1493, 0));

    #12;
    chk_all_zero("reset");
    chk("reset_b_valid", 32'(bus_b.valid_out), 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].b);
      chk($sformatf("v%0d_valid", i), 32'(bus_a.valid_out), 32'(vecs[i].ev));
      chk($sformatf("v%0d_on", i),    32'(bus_a.is_note_on_out), 32'(vecs[i].on));
      chk($sformatf("v%0d_note", i),  32'(bus_a.note_out), 32'(vecs[i].note));
      chk($sformatf("v%0d_vel", i),   32'(bus_a.velocity_out), 32'(vecs[i].vel));
      chk($sformatf("v%0d_rate", i),  32'(bus_a.cycles_between_samples_out), 32'(vecs[i].rate));
      chk($sformatf("v%0d_err", i),   32'(bus_a.error_count_out), 0);
      chk($sformatf("v%0d_b_valid", i), 32'(bus_b.valid_out), 32'(vecs[i].evb));
      if (vecs[i].evb) begin
        chk($sformatf("v%0d_b_on", i),   32'(bus_b.is_note_on_out), 32'(vecs[i].on));
        chk($sformatf("v%0d_b_note", i), 32'(bus_b.note_out), 32'(vecs[i].note));
        chk($sformatf("v%0d_b_vel", i),  32'(bus_b.velocity_out), 32'(vecs[i].vel));
        chk($sformatf("v%0d_b_rate", i), 32'(bus_b.cycles_between_samples_out), 32'(vecs[i].rate));
      end
    end

    // Orphan byte counts once; SysEx payload and terminator are dropped silently
    pulse_reset();
    drive(1'b1, 8'h45);
    drive(1'b0, 8'h00);
    chk("orphan_err", 32'(bus_a.error_count_out), 1);
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'hF7);
    repeat (3) drive(1'b0, 8'h00);
    chk("sysex_err", 32'(bus_a.error_count_out), 1);
    chk("sysex_events", 32'(evcount), 0);

    // Error counter saturation over 300 orphan bytes
    pulse_reset();
    repeat (254) drive(1'b1, 8'h11);
    chk("err_254", 32'(bus_a.error_count_out), 254);
    drive(1'b1, 8'h11);
    chk("err_255", 32'(bus_a.error_count_out), 255);
    repeat (45) drive(1'b1, 8'h11);
    chk("err_sat", 32'(bus_a.error_count_out), 255);

    // Asynchronous reset between status and first data byte
    pulse_reset();
    drive(1'b1, 8'h90);
    drive(1'b1, 8'h45);
    drive(1'b1, 8'h64);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    chk("pre_rst_note", 32'(bus_a.note_out), 69);
    chk("pre_rst_rate", 32'(bus_a.cycles_between_samples_out), 888);
    drive(1'b1, 8'h90);
    @(negedge clk_in);
    bus_a.byte_valid_in = 1'b0;
    bus_b.byte_valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk_in);
    rst_n = 1'b1;
    evcount = 0;
    drive(1'b1, 8'h45);
    drive(1'b1, 8'h64);
    repeat (3) drive(1'b0, 8'h00);
    chk("post_rst_events", 32'(evcount), 0);
    chk("post_rst_err", 32'(bus_a.error_count_out), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_message_parser.md
Name: midi_message_parser

Overview:
Converts the raw MIDI byte stream from the UART receiver into single-cycle note events for the MIDI coordinator. Outputs carry note on/off, note number, velocity and oscillator playback rate (clock cycles between wavetable samples). Supports running status, channel filtering and transparent System Real-Time bytes. Sits between midi_uart_rx and midi_coordinator.

Parameters:
CLK_HZ, 100_000_000, system clock frequency used to build the rate table
WAVE_SAMPLES, 256, wavetable length per oscillator period
OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL
CHANNEL, 0, 4-bit MIDI channel accepted when OMNI=0

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous assert, active-low
byte_in  input  8  received MIDI byte
byte_valid_in  input  1  byte_in valid this cycle; no backpressure
valid_out  output  1  one-cycle event strobe
is_note_on_out  output  1  1 = note on, 0 = note off
cycles_between_samples_out  output  24  playback rate for note_out
note_out  output  7  MIDI note number
velocity_out  output  7  MIDI velocity (0 on note off)
error_count_out  output  8  saturating count of dropped orphan data bytes

Behaviour:
- Reset (async on rst_n_in=0): all outputs 0; running status cleared; state WAIT_STATUS.
- Byte classes: >=0xF8 real-time; 0xF0-0xF7 system common/SysEx; 0x80-0xEF channel status; <0x80 data.
- Real-time bytes: ignored entirely; no change to state, running status or data already collected.
- 0xF0-0xF7: clear running status; go to WAIT_STATUS; subsequent data bytes (e.g. SysEx payload) are silently dropped and do not count as errors until the next channel status byte.
- Channel status: latch as running status, set need = 1 for 0xC0/0xD0 types and 2 otherwise; go to WAIT_D1. A status arriving mid-message discards the partial message.
- States: WAIT_STATUS, WAIT_D1, WAIT_D2.
- WAIT_STATUS + data byte: drop it. If no running status and not in a SysEx/system common context, increment error_count_out, saturating at 255.
- WAIT_D1 + data byte: store d1. If need=1, the message is complete; stay in WAIT_D1 (running status). Otherwise go to WAIT_D2.
- WAIT_D2 + data byte: store d2; the message is complete; return to WAIT_D1 (running status).
- Completion emits an event only when status type is 0x9n or 0x8n and the channel passes the filter. All other messages are consumed with no output.
- 0x9n with velocity 0 produces a note off. For any note off, velocity_out = 0.
- Latency: completing byte accepted at cycle N -> valid_out=1 at N+2 (one cycle decode register, one cycle registered LUT read). Output fields stay valid and held until the next event. valid_out is high for exactly one cycle.
- Messages need at least 2 bytes, so events are spaced at least 2 cycles apart. No event queue is required.
- Rate table: entry[n] = round(CLK_HZ / (440 * 2^((n-69)/12) * WAVE_SAMPLES)), 128 entries. Assertion: every entry is nonzero and fits in 24 bits.
- byte_valid_in low: no state change.

Decomposition:
- Package midi_pkg: byte-class constants (STATUS_NOTE_OFF=4'h8, STATUS_NOTE_ON=4'h9, SYS_RT_MIN=8'hF8, SYS_COMMON_MIN=8'hF0), parser state enum, function computing the rate table entry.
- One sub-module: midi_note_rate_lut, a 128x24 synchronous ROM initialised from the midi_pkg function, with 1-cycle read latency.

Test Plan:
- 0x90,0x45,0x64 back-to-back -> one valid_out 2 cycles after the last byte: is_note_on=1, note=69, velocity=100, rate=888.
- Running status: 0x90,0x45,0x64,0x51,0x00 -> two events: on note 69 rate 888, then off note 81 velocity 0 rate 444.
- 0x90,0x45, then 0xF8, then 0x64 -> identical to the first scenario; the real-time byte causes no disturbance.
- OMNI=0, CHANNEL=2: 0x91,0x45,0x64 -> no event; 0x82,0x45,0x40 -> off event, note 69, velocity 0.
- After reset, 0x45 then 0xF0,0x01,0x02,0xF7 -> error_count_out=1, no event. Then 300 orphan data bytes -> error_count_out=255.
- Pull rst_n_in low between 0x90 and 0x45 -> outputs 0 immediately. After release, 0x45,0x64 produce no event and error_count_out=2.
